// File: rtl/sram_if_pkg.sv
// ----------------------------------------------------------------------------
// sram_if_pkg
//   Shared constants and types for the generic single-port SRAM interface.
//   Defaults describe the 64x512 sky130 SRAM macro wrapper:
//     SramWords     : words in the macro
//     SramDataWidth : data bits per word
//     SramByteWidth : bits covered by one byte-enable bit
//   Types sram_addr_t / sram_data_t / sram_be_t are sized from these defaults.
// ----------------------------------------------------------------------------
package sram_if_pkg;

   localparam int unsigned SramWords     = 512;
   localparam int unsigned SramDataWidth = 64;
   localparam int unsigned SramByteWidth = 8;

   localparam int unsigned SramAddrWidth = (SramWords > 1) ? $clog2(SramWords) : 1;
   localparam int unsigned SramBeWidth   = (SramDataWidth + SramByteWidth - 1) / SramByteWidth;

   typedef logic [SramAddrWidth-1:0] sram_addr_t;
   typedef logic [SramDataWidth-1:0] sram_data_t;
   typedef logic [SramBeWidth-1:0]   sram_be_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// ----------------------------------------------------------------------------
// sram_rsp_fifo
//   Response FIFO holding SRAM read data until the consumer takes it.
//   Depth need not be a power of two; pointers wrap modulo Depth.
//   The head entry comes straight from storage, so a push into an empty FIFO
//   is visible on the following cycle (no fall-through).
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push, wdata   : write an entry (ignored when full)
//   pop           : remove the head entry (ignored when empty)
//   rdata         : head entry
//   full, empty   : status flags
//   occupancy     : number of stored entries, 0..Depth
// ----------------------------------------------------------------------------
module sram_rsp_fifo #(
   parameter  int unsigned Depth    = 3,
   parameter  int unsigned Width    = 64,
   localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1,
   localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                push,
   input  logic [Width-1:0]    wdata,
   input  logic                pop,
   output logic [Width-1:0]    rdata,
   output logic                full,
   output logic                empty,
   output logic [CntWidth-1:0] occupancy
);

   logic [Width-1:0]    mem [Depth];
   logic [PtrWidth-1:0] wr_ptr;
   logic [PtrWidth-1:0] rd_ptr;
   logic [CntWidth-1:0] count;
   logic                push_en;
   logic                pop_en;

   function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
      return (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + 1'b1;
   endfunction

   assign push_en   = push & ~full;
   assign pop_en    = pop & ~empty;
   assign full      = (count == CntWidth'(Depth));
   assign empty     = (count == '0);
   assign occupancy = count;
   assign rdata     = mem[rd_ptr];

   // NOTE: storage has no reset; an entry is only visible once count covers it,
   // so its power-up contents never matter and it maps onto plain flops/RAM.
   always_ff @(posedge clk_i) begin
      if (push_en) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_en) wr_ptr <= next_ptr(wr_ptr);
         if (pop_en)  rd_ptr <= next_ptr(rd_ptr);
         unique case ({push_en, pop_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sram_req_initiator.sv
// ----------------------------------------------------------------------------
// sram_req_initiator
//   Initiator side of a single-port generic SRAM. Turns a valid/ready request
//   stream into SRAM port cycles and returns read data, in issue order, on a
//   valid/ready response stream. Read data is always captured into a response
//   FIFO, so a stalled consumer never loses data coming out of the SRAM.
//
//   A read is only accepted when the FIFO is guaranteed to have room for it
//   when its data arrives: occupancy + reads still in the SRAM pipe < depth.
//   Writes are always accepted and produce no response.
//
//   Legal parameters: Latency 1..4, FifoDepth >= Latency+1
//   (FifoDepth >= Latency+2 for one read per cycle).
// Ports:
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   req_valid_i/req_ready_o : request handshake
//   req_we_i, req_addr_i,
//   req_wdata_i, req_be_i   : request fields (be used for writes only)
//   rsp_valid_o/rsp_ready_i : read response handshake
//   rsp_rdata_o             : read data, in request order
//   sram_req_o .. sram_be_o : SRAM port, driven combinationally from request
//   sram_rdata_i            : SRAM read data, Latency cycles after the read
// ----------------------------------------------------------------------------
module sram_req_initiator
   import sram_if_pkg::*;
#(
   parameter  int unsigned NumWords  = SramWords,
   parameter  int unsigned DataWidth = SramDataWidth,
   parameter  int unsigned ByteWidth = SramByteWidth,
   parameter  int unsigned Latency   = 1,
   parameter  int unsigned FifoDepth = 3,
   localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
   localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_we_i,
   input  logic [AddrWidth-1:0] req_addr_i,
   input  logic [DataWidth-1:0] req_wdata_i,
   input  logic [BeWidth-1:0]   req_be_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [DataWidth-1:0] rsp_rdata_o,
   output logic                 sram_req_o,
   output logic                 sram_we_o,
   output logic [AddrWidth-1:0] sram_addr_o,
   output logic [DataWidth-1:0] sram_wdata_o,
   output logic [BeWidth-1:0]   sram_be_o,
   input  logic [DataWidth-1:0] sram_rdata_i
);

   localparam int unsigned IflWidth    = $clog2(Latency + 1);
   localparam int unsigned OccWidth    = $clog2(FifoDepth + 1);
   localparam int unsigned CreditWidth = $clog2(FifoDepth + Latency + 1);

   logic [Latency-1:0]     rd_pipe;      // one bit per cycle of SRAM read latency
   logic [IflWidth-1:0]    inflight;
   logic [OccWidth-1:0]    occupancy;
   logic [CreditWidth-1:0] credit_used;
   logic                   credit_ok;
   logic                   issue;
   logic                   issue_read;
   logic                   push;
   logic                   pop;
   logic                   fifo_full;
   logic                   fifo_empty;

   // ---------------------------------------------------------------- credit
   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < int'(Latency); i++) begin
         inflight = inflight + IflWidth'(rd_pipe[i]);
      end
   end

   // Uses the registered occupancy only: a pop frees its credit next cycle,
   // which keeps rsp_ready_i out of the req_ready_o path.
   assign credit_used = CreditWidth'(occupancy) + CreditWidth'(inflight);
   assign credit_ok   = (credit_used < CreditWidth'(FifoDepth));
   assign req_ready_o = rst_ni & (req_we_i | credit_ok);

   // ----------------------------------------------------------------- issue
   assign issue        = req_valid_i & req_ready_o;
   assign issue_read   = issue & ~req_we_i;

   assign sram_req_o   = issue;
   assign sram_we_o    = issue & req_we_i;
   assign sram_addr_o  = req_addr_i;
   assign sram_wdata_o = req_wdata_i;
   assign sram_be_o    = issue ? req_be_i : '0;

   // -------------------------------------------------------- read pipeline
   // Bit i set means a read issued i+1 edges ago; the bit leaving the top
   // marks the cycle its data is on sram_rdata_i.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_pipe <= '0;
      end else begin
         rd_pipe[0] <= issue_read;
         for (int i = 1; i < int'(Latency); i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
         end
      end
   end

   assign push = rd_pipe[Latency-1];
   assign pop  = rsp_valid_o & rsp_ready_i;

   // -------------------------------------------------------- response FIFO
   sram_rsp_fifo #(
      .Depth (FifoDepth),
      .Width (DataWidth)
   ) u_rsp_fifo (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .push      (push),
      .wdata     (sram_rdata_i),
      .pop       (pop),
      .rdata     (rsp_rdata_o),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .occupancy (occupancy)
   );

   assign rsp_valid_o = ~fifo_empty;

   // ------------------------------------------------------------ assertions
   fifo_no_overflow_a: assert property (
      @(posedge clk_i) disable iff (!rst_ni) !(push && fifo_full)
   ) else $error("sram_req_initiator: read data pushed into a full response FIFO");

   rsp_stable_a: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      (rsp_valid_o && !rsp_ready_i) |=> (rsp_valid_o && $stable(rsp_rdata_o))
   ) else $error("sram_req_initiator: response changed while stalled");

   // Only a non-power-of-two SRAM can see an address beyond its last word.
   if (NumWords != (1 << AddrWidth)) begin : g_addr_chk
      addr_range_a: assert property (
         @(posedge clk_i) disable iff (!rst_ni)
         sram_req_o |-> (32'(sram_addr_o) < NumWords)
      ) else $warning("sram_req_initiator: address 0x%0h beyond NumWords", sram_addr_o);
   end

endmodule

// File: tb/tb_sram_req_initiator.sv
// ----------------------------------------------------------------------------
// tb_sram_req_initiator
//   Two instances: env 0 (Latency 1, FifoDepth 3) and env 1 (Latency 3,
//   FifoDepth 5), each attached to a behavioural SRAM. A reference model per
//   env keeps the outstanding-read queue (expected data and the cycle it may
//   first appear) and a reference memory; a compare process checks the DUT
//   against it every cycle. Directed tests add literal expectations.
// ----------------------------------------------------------------------------
module tb_sram_req_initiator;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_we    [2];
   logic [8:0]  req_addr  [2];
   logic [63:0] req_wdata [2];
   logic [7:0]  req_be    [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [63:0] rsp_rdata [2];
   logic        sram_req  [2];
   logic        sram_we   [2];
   logic [8:0]  sram_addr [2];
   logic [63:0] sram_wdata[2];
   logic [7:0]  sram_be   [2];
   logic [63:0] sram_rdata[2];

   int          checks = 0;
   int          errors = 0;
   int          n_rsp  [2];
   int          n_acc  [2];
   int          n_sreq [2];
   logic [63:0] last_rsp [2];
   bit          rand_rsp [2];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_env
      localparam int L = (g == 0) ? 1 : 3;
      localparam int D = (g == 0) ? 3 : 5;

      typedef struct {
         logic [63:0] data;
         int          avail;
      } exp_t;

      exp_t        q [$];
      logic [63:0] ref_mem  [512];
      logic [63:0] sram_mem [512];
      logic [63:0] rd_pipe  [L];

      sram_req_initiator #(
         .Latency   (L),
         .FifoDepth (D)
      ) u_dut (
         .clk_i        (clk),
         .rst_ni       (rst_n),
         .req_valid_i  (req_valid[g]),
         .req_ready_o  (req_ready[g]),
         .req_we_i     (req_we[g]),
         .req_addr_i   (req_addr[g]),
         .req_wdata_i  (req_wdata[g]),
         .req_be_i     (req_be[g]),
         .rsp_valid_o  (rsp_valid[g]),
         .rsp_ready_i  (rsp_ready[g]),
         .rsp_rdata_o  (rsp_rdata[g]),
         .sram_req_o   (sram_req[g]),
         .sram_we_o    (sram_we[g]),
         .sram_addr_o  (sram_addr[g]),
         .sram_wdata_o (sram_wdata[g]),
         .sram_be_o    (sram_be[g]),
         .sram_rdata_i (sram_rdata[g])
      );

      // Behavioural SRAM: byte-masked write, read data L cycles later.
      always @(posedge clk) begin
         if (sram_req[g] && sram_we[g]) begin
            for (int b = 0; b < 8; b++) begin
               if (sram_be[g][b]) sram_mem[sram_addr[g]][b*8 +: 8] <= sram_wdata[g][b*8 +: 8];
            end
         end
         rd_pipe[0] <= (sram_req[g] && !sram_we[g]) ? sram_mem[sram_addr[g]] : 64'hBADC0FFEE0DDF00D;
         for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
      end
      assign sram_rdata[g] = rd_pipe[L-1];

      // Reference model and per-cycle comparison.
      always @(negedge clk) begin : cmp
         bit er;
         bit ev;
         if (!rst_n) begin
            q.delete();
            check($sformatf("e%0d reset rsp_valid", g), rsp_valid[g], 0);
            check($sformatf("e%0d reset req_ready", g), req_ready[g], 0);
            check($sformatf("e%0d reset sram_req", g), sram_req[g], 0);
         end else begin
            er = req_we[g] || (q.size() < D);
            check($sformatf("e%0d req_ready", g), req_ready[g], er);
            check($sformatf("e%0d sram_req", g), sram_req[g], req_valid[g] && er);
            if (req_valid[g] && er) begin
               check($sformatf("e%0d sram_we", g), sram_we[g], req_we[g]);
               check($sformatf("e%0d sram_addr", g), sram_addr[g], req_addr[g]);
               check($sformatf("e%0d sram_be", g), sram_be[g], req_be[g]);
               if (req_we[g]) check($sformatf("e%0d sram_wdata", g), sram_wdata[g], req_wdata[g]);
            end else begin
               check($sformatf("e%0d idle sram_we", g), sram_we[g], 0);
               check($sformatf("e%0d idle sram_be", g), sram_be[g], 0);
            end
            ev = (q.size() > 0) && (q[0].avail <= cyc);
            check($sformatf("e%0d rsp_valid", g), rsp_valid[g], ev);
            if (ev) check($sformatf("e%0d rsp_rdata", g), rsp_rdata[g], q[0].data);

            if (sram_req[g]) n_sreq[g]++;
            if (rsp_valid[g] && rsp_ready[g]) begin
               n_rsp[g]++;
               last_rsp[g] = rsp_rdata[g];
            end
            if (req_valid[g] && req_ready[g] && !req_we[g]) n_acc[g]++;

            if (ev && rsp_ready[g]) void'(q.pop_front());
            if (req_valid[g] && er) begin
               if (req_we[g]) begin
                  for (int b = 0; b < 8; b++) begin
                     if (req_be[g][b]) ref_mem[req_addr[g]][b*8 +: 8] = req_wdata[g][b*8 +: 8];
                  end
               end else begin
                  q.push_back('{data: ref_mem[req_addr[g]], avail: cyc + 1 + L});
               end
            end
         end
      end
   end

   // ------------------------------------------------------------ stimulus
   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input int e);
      sync();
      if (rand_rsp[e]) rsp_ready[e] = 1'($urandom_range(0, 1));
   endtask

   task automatic issue(input int e, input logic we, input logic [8:0] a,
                        input logic [63:0] d, input logic [7:0] be);
      bit acc = 0;
      req_we[e]    = we;
      req_addr[e]  = a;
      req_wdata[e] = d;
      req_be[e]    = be;
      req_valid[e] = 1'b1;
      for (int i = 0; i < 100 && !acc; i++) begin
         @(negedge clk);
         acc = req_ready[e];
         step(e);
      end
      req_valid[e] = 1'b0;
      if (!acc) check("issue accepted", 0, 1);
   endtask

   task automatic wait_rsp(input int e, input int target);
      for (int i = 0; i < 300 && n_rsp[e] < target; i++) step(e);
      if (n_rsp[e] < target) check("response timeout", 64'(n_rsp[e]), 64'(target));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          s0, r0, a0, t0;
      bit          acc;
      logic [63:0] stream_data [20];

      rst_n = 1'b0;
      for (int e = 0; e < 2; e++) begin
         req_valid[e] = 0; req_we[e] = 0; req_addr[e] = '0;
         req_wdata[e] = '0; req_be[e] = '0; rsp_ready[e] = 0; rand_rsp[e] = 0;
      end
      @(negedge clk);
      check("in reset rsp_valid", rsp_valid[0], 0);
      check("in reset req_ready", req_ready[0], 0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      sync();

      // Write then read one word; response two cycles after read accept.
      rsp_ready[0] = 1'b1;
      s0 = n_sreq[0];
      r0 = n_rsp[0];
      issue(0, 1'b1, 9'h010, 64'hDEADBEEF_01234567, 8'hFF);
      issue(0, 1'b0, 9'h010, 64'h0, 8'h00);
      @(negedge clk);
      check("t1 rsp_valid one cycle after accept", rsp_valid[0], 0);
      @(negedge clk);
      check("t1 rsp_valid two cycles after accept", rsp_valid[0], 1);
      check("t1 rsp_rdata", rsp_rdata[0], 64'hDEADBEEF_01234567);
      @(negedge clk);
      check("t1 rsp_valid single cycle", rsp_valid[0], 0);
      check("t1 sram_req pulses", 64'(n_sreq[0] - s0), 2);
      check("t1 response count", 64'(n_rsp[0] - r0), 1);
      sync();

      // Back-to-back reads 0..7 with data = address.
      for (int i = 0; i < 8; i++) issue(0, 1'b1, 9'(i), 64'(i), 8'hFF);
      t0 = cyc;
      r0 = n_rsp[0];
      for (int i = 0; i < 8; i++) issue(0, 1'b0, 9'(i), 64'h0, 8'h00);
      check("t2 eight reads in eight cycles", 64'(cyc - t0), 8);
      wait_rsp(0, r0 + 8);
      check("t2 response count", 64'(n_rsp[0] - r0), 8);
      check("t2 last response", last_rsp[0], 64'd7);

      // Backpressure: only FifoDepth reads fit while the consumer stalls.
      rsp_ready[0] = 1'b0;
      a0 = n_acc[0];
      req_we[0]    = 1'b0;
      req_be[0]    = 8'h00;
      req_addr[0]  = 9'h001;
      req_valid[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         acc = req_ready[0];
         step(0);
         if (acc) req_addr[0] = req_addr[0] + 9'h001;
      end
      req_valid[0] = 1'b0;
      check("t3 reads accepted under stall", 64'(n_acc[0] - a0), 3);
      @(negedge clk);
      check("t3 read ready low", req_ready[0], 0);
      sync();
      issue(0, 1'b1, 9'h020, 64'h55, 8'hFF);
      r0 = n_rsp[0];
      rsp_ready[0] = 1'b1;
      wait_rsp(0, r0 + 3);
      check("t3 drained count", 64'(n_rsp[0] - r0), 3);
      check("t3 last drained", last_rsp[0], 64'd3);
      r0 = n_rsp[0];
      issue(0, 1'b0, 9'h020, 64'h0, 8'h00);
      wait_rsp(0, r0 + 1);
      check("t3 read after drain", last_rsp[0], 64'h55);

      // Byte mask, including a write with no enables.
      issue(0, 1'b1, 9'h1FF, 64'hFFFFFFFF_FFFFFFFF, 8'hFF);
      issue(0, 1'b1, 9'h1FF, 64'h0, 8'h0F);
      issue(0, 1'b1, 9'h1FF, 64'h1234, 8'h00);
      r0 = n_rsp[0];
      issue(0, 1'b0, 9'h1FF, 64'h0, 8'h00);
      wait_rsp(0, r0 + 1);
      check("t4 masked data", last_rsp[0], 64'hFFFFFFFF_00000000);

      // Reset with two responses queued and one read still in the SRAM.
      rsp_ready[0] = 1'b0;
      r0 = n_rsp[0];
      issue(0, 1'b0, 9'h000, 64'h0, 8'h00);
      issue(0, 1'b0, 9'h001, 64'h0, 8'h00);
      issue(0, 1'b0, 9'h002, 64'h0, 8'h00);
      #2 rst_n = 1'b0;
      #1 check("t5 rsp_valid drops in reset", rsp_valid[0], 0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      rsp_ready[0] = 1'b1;
      repeat (6) step(0);
      check("t5 no stale responses", 64'(n_rsp[0] - r0), 0);
      issue(0, 1'b0, 9'h010, 64'h0, 8'h00);
      wait_rsp(0, r0 + 1);
      check("t5 read after reset", last_rsp[0], 64'hDEADBEEF_01234567);

      // Latency 3 / depth 5: stream of 20 reads with random consumer stalls.
      for (int i = 0; i < 20; i++) begin
         stream_data[i] = {$urandom, $urandom};
         issue(1, 1'b1, 9'(9'h040 + i), stream_data[i], 8'hFF);
      end
      r0 = n_rsp[1];
      rand_rsp[1] = 1'b1;
      for (int i = 0; i < 20; i++) issue(1, 1'b0, 9'(9'h040 + i), 64'h0, 8'h00);
      wait_rsp(1, r0 + 20);
      rand_rsp[1]  = 1'b0;
      rsp_ready[1] = 1'b1;
      check("t6 response count", 64'(n_rsp[1] - r0), 20);
      check("t6 last response", last_rsp[1], stream_data[19]);

      repeat (3) sync();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_req_initiator.md
Name: sram_req_initiator

Overview:
- Initiator side of the single-port generic SRAM interface (req/we/addr/wdata/be in, rdata out `Latency` cycles after a read).
- Converts a valid/ready request stream from a core or cache into SRAM port cycles.
- Tracks in-flight reads and buffers read data in a response FIFO, so a stalled consumer never loses SRAM data.
- Sits between the cache/memory arbiter and the 64x512 sky130 SRAM macro wrapper.

Parameters:
- NumWords, 512, words in the attached SRAM.
- DataWidth, 64, data width.
- ByteWidth, 8, bits per byte enable.
- Latency, 1, SRAM read latency in cycles; legal range 1..4.
- FifoDepth, 3, response FIFO entries; must be >= Latency+1; full read throughput requires >= Latency+2.
- AddrWidth, derived, (NumWords>1) ? clog2(NumWords) : 1.
- BeWidth, derived, ceil(DataWidth/ByteWidth).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid && ready.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  AddrWidth  word address.
- req_wdata_i  in  DataWidth  write data.
- req_be_i  in  BeWidth  byte enables, writes only.
- rsp_valid_o  out  1  read data valid.
- rsp_ready_i  in  1  consumer accepts read data.
- rsp_rdata_o  out  DataWidth  read data, in request order.
- sram_req_o  out  1  SRAM request.
- sram_we_o  out  1  SRAM write enable.
- sram_addr_o  out  AddrWidth  SRAM address.
- sram_wdata_o  out  DataWidth  SRAM write data.
- sram_be_o  out  BeWidth  SRAM byte enables.
- sram_rdata_i  in  DataWidth  SRAM read data.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - inflight pipeline, FIFO pointers and occupancy cleared.
  - rsp_valid_o = 0.
  - req_ready_o forced 0; sram_req_o = 0.
  - In-flight reads are discarded. No response appears for a read issued before reset, even if its SRAM data returns afterwards.
- Issue (combinational pass-through):
  - sram_req_o = req_valid_i && req_ready_o.
  - sram_we_o/addr/wdata/be = request fields.
  - sram_we_o and sram_be_o are driven 0 when sram_req_o = 0. Addr and wdata are don't-care then.
- Ready:
  - Writes: req_ready_o = 1 whenever out of reset.
  - Reads: req_ready_o = (occupancy + inflight) < FifoDepth.
  - req_ready_o never depends combinationally on rsp_ready_i; a pop frees a credit from the next cycle.
- Inflight tracking:
  - Latency-deep shift register of read-issued bits, shifting every cycle.
  - inflight = popcount of the register, range 0..Latency.
  - Writes insert 0.
- Capture: when the bit leaving the shift register is 1, sram_rdata_i is pushed into the FIFO at that clock edge.
  - Overflow is impossible by the credit rule.
  - Push to a full FIFO is an assertion failure.
- Response:
  - rsp_valid_o = FIFO not empty; rsp_rdata_o = FIFO head (registered).
  - Pop on rsp_valid_o && rsp_ready_i.
  - Push and pop in the same cycle keep occupancy unchanged.
  - Push into an empty FIFO becomes visible on the next cycle; there is no fall-through.
- Latency: read accepted at edge N -> rsp_valid_o high in the cycle after edge N+Latency, i.e. Latency+1 cycles.
- Ordering: responses strictly in issue order. Writes produce no response.
- Write with req_be_i = 0: still issued to the SRAM, no effect, no response.
- Pointer wrap: modulo FifoDepth; FifoDepth need not be a power of two.
- Stability: rsp_rdata_o holds while rsp_valid_o && !rsp_ready_i. Assertions check this and that the FIFO never overflows.
- Address range: out-of-range addresses are impossible, since NumWords = 2^AddrWidth by default. For non-power-of-two NumWords, a simulation warning fires on addr >= NumWords and the request is still issued.

Decomposition:
- Shared package sram_if_pkg:
  - default constants for the sky130 macro: SramWords = 512, SramDataWidth = 64, SramByteWidth = 8.
  - typedefs sram_addr_t, sram_data_t, sram_be_t.
- Sub-module sram_rsp_fifo: parameterised depth/width, push/pop/full/empty/occupancy.
- Credit and shift-register logic stays in the top.

Test Plan:
- Latency = 1, FifoDepth = 3: write addr 0x010 data 0xDEADBEEF_01234567 be 0xFF, then read 0x010 with rsp_ready_i = 1 -> sram_req_o pulses twice; rsp_valid_o one cycle only, rdata 0xDEADBEEF_01234567, 2 cycles after read accept.
- Back-to-back reads 0x000..0x007 (data = address), rsp_ready_i = 1 -> req_ready_o never drops; 8 responses in order 0..7 on consecutive cycles.
- Backpressure: rsp_ready_i = 0, issue 5 reads -> exactly 3 accepted, then req_ready_o = 0. A write issued meanwhile is accepted. Raising rsp_ready_i drains 3 responses in order, then read acceptance resumes.
- Byte mask: write 0xFFFF..FF be 0xFF, then 0x0 be 0x0F to addr 0x1FF, then read -> 0xFFFFFFFF_00000000.
- Reset mid-operation: assert rst_ni low one cycle after a read accept with 2 responses queued -> rsp_valid_o = 0 immediately and no response ever appears for those reads. After release, a new read returns correct data.
- Latency = 3, FifoDepth = 5: stream 20 reads with random rsp_ready_i -> order preserved, no drops, occupancy + inflight <= 5.
